// File: rtl/bt656_timing_decoder_if.sv
// BT.656 stream and decoded-timing bundle between the timing decoder and its consumers.
// master: the decoder side; slave: the downstream consumer / stream source side.
interface bt656_timing_decoder_if #(
  parameter int unsigned SAMPLE_W = 11,
  parameter int unsigned LINE_W   = 10
);
  logic [9:0]          bt656_stream_in;
  logic [9:0]          bt656_stream_out;
  logic                field;
  logic                vblank;
  logic                hblank;
  logic                active_video;
  logic                sav_pulse;
  logic                eav_pulse;
  logic [LINE_W-1:0]   line_count;
  logic [SAMPLE_W-1:0] sample_count;
  logic                trs_error;
  logic                locked;

  modport master (
    input  bt656_stream_in,
    output bt656_stream_out, field, vblank, hblank, active_video,
           sav_pulse, eav_pulse, line_count, sample_count, trs_error, locked
  );

  modport slave (
    output bt656_stream_in,
    input  bt656_stream_out, field, vblank, hblank, active_video,
           sav_pulse, eav_pulse, line_count, sample_count, trs_error, locked
  );
endinterface

// File: rtl/bt656_timing_decoder.sv
// BT.656 TRS detector: re-emits the stream one cycle late and produces F/V/H timing,
// line/sample counters and a lock flag aligned with the re-emitted word.
module bt656_timing_decoder #(
  parameter int unsigned SAMPLE_W   = 11,
  parameter int unsigned LINE_W     = 10,
  parameter int unsigned LOCK_LINES = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  bt656_timing_decoder_if.master bus
);
  localparam int unsigned LOCK_W = $clog2(LOCK_LINES + 1);

  typedef enum logic [1:0] {IDLE, S_FF, S_Z1, S_Z2} state_e;

  state_e              state_q, state_d;
  logic                xy_pend_q, xy_pend_d;
  logic [9:0]          stream_q, stream_d;
  logic                field_q, field_d;
  logic                vblank_q, vblank_d;
  logic                hblank_q, hblank_d;
  logic                sav_q, sav_d;
  logic                eav_q, eav_d;
  logic                err_q, err_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic [LOCK_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic                locked_q, locked_d;

  logic xy_f, xy_v, xy_h, xy_ok, sample_sat;

  // The XY word is checked one cycle after capture, from stream_q, so every
  // timing update lands on the same edge that shows the word after XY.
  always_comb begin
    xy_f       = stream_q[8];
    xy_v       = stream_q[7];
    xy_h       = stream_q[6];
    xy_ok      = stream_q[9]
               & (stream_q[5] == (xy_v ^ xy_h))
               & (stream_q[4] == (xy_f ^ xy_h))
               & (stream_q[3] == (xy_f ^ xy_v))
               & (stream_q[2] == (xy_f ^ xy_v ^ xy_h));
    sample_sat = &sample_q;
  end

  always_comb begin
    state_d    = IDLE;
    xy_pend_d  = (state_q == S_Z2);
    stream_d   = bus.bt656_stream_in;
    field_d    = field_q;
    vblank_d   = vblank_q;
    hblank_d   = hblank_q;
    sav_d      = 1'b0;
    eav_d      = 1'b0;
    err_d      = 1'b0;
    line_d     = line_q;
    sample_d   = sample_q;
    lock_cnt_d = lock_cnt_q;

    unique case (state_q)
      IDLE: state_d = (bus.bt656_stream_in == 10'h3FF) ? S_FF : IDLE;
      S_FF, S_Z1: begin
        if (bus.bt656_stream_in == 10'h000)      state_d = (state_q == S_FF) ? S_Z1 : S_Z2;
        else if (bus.bt656_stream_in == 10'h3FF) state_d = S_FF;
        else                                     state_d = IDLE;
      end
      S_Z2: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (xy_pend_q && xy_ok) begin
      field_d  = xy_f;
      vblank_d = xy_v;
      hblank_d = xy_h;
      sample_d = '0;
      if (xy_h) begin
        eav_d = 1'b1;
        if (xy_f != field_q) line_d = '0;
        else if (!(&line_q)) line_d = line_q + LINE_W'(1);
        if (lock_cnt_q != LOCK_W'(LOCK_LINES)) lock_cnt_d = lock_cnt_q + LOCK_W'(1);
      end else begin
        sav_d = 1'b1;
      end
    end else begin
      if (!sample_sat) sample_d = sample_q + SAMPLE_W'(1);
      if (xy_pend_q) begin
        err_d      = 1'b1;
        lock_cnt_d = '0;
      end else if (sample_sat) begin
        lock_cnt_d = '0;
      end
    end

    locked_d = (lock_cnt_d == LOCK_W'(LOCK_LINES));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      xy_pend_q  <= 1'b0;
      stream_q   <= '0;
      field_q    <= 1'b0;
      vblank_q   <= 1'b1;
      hblank_q   <= 1'b1;
      sav_q      <= 1'b0;
      eav_q      <= 1'b0;
      err_q      <= 1'b0;
      line_q     <= '0;
      sample_q   <= '0;
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      xy_pend_q  <= xy_pend_d;
      stream_q   <= stream_d;
      field_q    <= field_d;
      vblank_q   <= vblank_d;
      hblank_q   <= hblank_d;
      sav_q      <= sav_d;
      eav_q      <= eav_d;
      err_q      <= err_d;
      line_q     <= line_d;
      sample_q   <= sample_d;
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
    end
  end

  assign bus.bt656_stream_out = stream_q;
  assign bus.field            = field_q;
  assign bus.vblank           = vblank_q;
  assign bus.hblank           = hblank_q;
  assign bus.active_video     = ~vblank_q & ~hblank_q;
  assign bus.sav_pulse        = sav_q;
  assign bus.eav_pulse        = eav_q;
  assign bus.line_count       = line_q;
  assign bus.sample_count     = sample_q;
  assign bus.trs_error        = err_q;
  assign bus.locked           = locked_q;
endmodule

// File: tb/tb_bt656_timing_decoder.sv
// Scoreboard bench: a behavioural model queues the expected outputs for every driven
// word; after each clock edge the entry is popped and compared field by field.
module tb_bt656_timing_decoder;
  localparam int SAMPLE_MAX = 2047;
  localparam int LINE_MAX   = 1023;
  localparam int LOCK_LINES = 4;

  logic clk;
  logic reset_n;

  bt656_timing_decoder_if #(.SAMPLE_W(11), .LINE_W(10)) bus ();

  bt656_timing_decoder #(.SAMPLE_W(11), .LINE_W(10), .LOCK_LINES(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [9:0] out;
    logic f, v, h, act, sav, eav, err, lck;
    int line, sample;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [9:0] mkxy(input logic f, input logic v, input logic h);
    return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h, 2'b00};
  endfunction

  function automatic logic xy_good(input logic [9:0] w);
    logic [9:0] ref_xy;
    ref_xy = mkxy(w[8], w[7], w[6]);
    return (w[9:2] == ref_xy[9:2]);
  endfunction

  // Reference model state
  exp_t       m;
  int         m_st;
  logic       m_pend;
  logic [9:0] m_xy;
  int         m_lcnt;

  task automatic model_step(input logic [9:0] w, input logic rst);
    logic lost;
    if (rst) begin
      m.out = '0; m.f = 0; m.v = 1; m.h = 1;
      m.sav = 0; m.eav = 0; m.err = 0;
      m.line = 0; m.sample = 0;
      m_lcnt = 0; m_st = 0; m_pend = 0;
    end else begin
      m.sav = 0; m.eav = 0; m.err = 0;
      lost = (m.sample == SAMPLE_MAX);
      if (m_pend && xy_good(m_xy)) begin
        if (m_xy[6]) begin
          m.eav = 1;
          if (m_xy[8] != m.f) m.line = 0;
          else if (m.line < LINE_MAX) m.line++;
          if (m_lcnt < LOCK_LINES) m_lcnt++;
        end else begin
          m.sav = 1;
        end
        m.f = m_xy[8]; m.v = m_xy[7]; m.h = m_xy[6];
        m.sample = 0;
      end else begin
        if (m.sample < SAMPLE_MAX) m.sample++;
        if (m_pend) begin
          m.err = 1;
          m_lcnt = 0;
        end else if (lost) begin
          m_lcnt = 0;
        end
      end
      m.out  = w;
      m_pend = (m_st == 3);
      if (m_pend) m_xy = w;
      case (m_st)
        0:       m_st = (w == 10'h3FF) ? 1 : 0;
        1, 2:    m_st = (w == 10'h000) ? m_st + 1 : ((w == 10'h3FF) ? 1 : 0);
        default: m_st = 0;
      endcase
    end
    m.act = ~m.v & ~m.h;
    m.lck = (m_lcnt == LOCK_LINES);
    sb.push_back(m);
  endtask

  task automatic drive(input logic [9:0] w, input logic rst = 1'b0);
    exp_t e;
    bus.bt656_stream_in = w;
    reset_n = ~rst;
    model_step(w, rst);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("stream_out",   32'(bus.bt656_stream_out), 32'(e.out));
    check("field",        32'(bus.field),            32'(e.f));
    check("vblank",       32'(bus.vblank),           32'(e.v));
    check("hblank",       32'(bus.hblank),           32'(e.h));
    check("active_video", 32'(bus.active_video),     32'(e.act));
    check("sav_pulse",    32'(bus.sav_pulse),        32'(e.sav));
    check("eav_pulse",    32'(bus.eav_pulse),        32'(e.eav));
    check("trs_error",    32'(bus.trs_error),        32'(e.err));
    check("line_count",   32'(bus.line_count),       32'(e.line));
    check("sample_count", 32'(bus.sample_count),     32'(e.sample));
    check("locked",       32'(bus.locked),           32'(e.lck));
  endtask

  task automatic trs(input logic [9:0] xy);
    drive(10'h3FF); drive(10'h000); drive(10'h000); drive(xy);
  endtask

  task automatic video_line(input logic f, input logic v);
    trs(mkxy(f, v, 1'b1));
    for (int i = 0; i < 8; i++) drive(10'h040);
    trs(mkxy(f, v, 1'b0));
    for (int i = 0; i < 16; i++) drive(10'h200 + 10'(i));
  endtask

  initial begin
    logic [9:0] w;
    bus.bt656_stream_in = 10'h3FF;
    reset_n = 1'b0;

    for (int i = 0; i < 3; i++) drive(10'h3FF, 1'b1);

    trs(10'h2D8);
    for (int i = 0; i < 6; i++) drive(10'h040);
    trs(10'h200);
    for (int i = 0; i < 8; i++) drive(10'h200);

    trs(10'h2DC);
    for (int i = 0; i < 3; i++) drive(10'h040);

    for (int i = 0; i < 5; i++) video_line(1'b0, 1'b0);
    video_line(1'b1, 1'b0);
    video_line(1'b1, 1'b0);

    drive(10'h3FF); trs(mkxy(1'b1, 1'b0, 1'b1));
    for (int i = 0; i < 3; i++) drive(10'h040);

    drive(10'h3FF); drive(10'h000); drive(10'h123);
    for (int i = 0; i < 3; i++) drive(10'h040);

    trs(10'h3FF); drive(10'h000); drive(10'h000); drive(mkxy(1'b1, 1'b0, 1'b1));
    for (int i = 0; i < 3; i++) drive(10'h040);

    drive(10'h3FF); drive(10'h000); drive(10'h000, 1'b1);
    drive(10'h000); drive(mkxy(1'b0, 1'b0, 1'b1));
    for (int i = 0; i < 3; i++) drive(10'h040);

    for (int i = 0; i < 4; i++) video_line(1'b0, 1'b1);

    for (int i = 0; i < 2100; i++) drive(10'h040);

    for (int i = 0; i < 4; i++) video_line(1'b1, 1'b1);
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 4))
        0:       w = 10'h3FF;
        1, 2:    w = 10'h000;
        3:       w = mkxy(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)));
        default: w = 10'($urandom_range(0, 1023));
      endcase
      drive(w);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
